reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 33 +++
 rtl/reg_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
//==============================================================================
// Module      : reg_arb_pkg
// Description : Shared types and constants for the register-bus arbiter.
//               Holds the arbiter FSM state encoding, the default requester
//               and register counts, and the register-address width helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int c_NREQ_DEF = 4;
    localparam int c_NREG_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    // Address width wide enough to express the value NREG itself, so an
    // out-of-range register index is representable even when NREG is a
    // power of two (8 registers -> 4-bit index, indices 8..15 flag err).
    function automatic int aw_of(input int nreg);
        return $clog2(nreg + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//==============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches req starting at
//               index ptr and wrapping; returns the first active requester as
//               a one-hot vector (all zero when no request is active).
// Ports       : req    [NREQ-1:0] - active requests
//               ptr    [PW-1:0]   - index with highest priority this round
//               winner [NREQ-1:0] - one-hot selected requester
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner
);

    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_oh;

    // Rotate so that requester ptr sits at bit 0, isolate the lowest set
    // bit, then rotate the one-hot result back to absolute positions.
    assign w_rot    = NREQ'({req, req} >> ptr);
    assign w_rot_oh = w_rot & (-w_rot);
    assign winner   = NREQ'(({w_rot_oh, w_rot_oh} << ptr) >> NREQ);

endmodule

`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
//==============================================================================
// Module      : reg_bus_arbiter
// Description : Round-robin arbiter giving NREQ requesters access to a bank of
//               NREG 64-bit registers on a shared tri-state bus. Each
//               transaction is IDLE (arbitrate) -> GRANT -> ACCESS; the IDLE
//               that follows is a bus turnaround cycle. All outputs are decoded
//               from registered state only.
// Ports       : clk        - clock, rising edge
//               clr_n      - asynchronous active-low reset
//               req   [NREQ-1:0]    - per-requester request (level held)
//               wr    [NREQ-1:0]    - per-requester op, 1 = write
//               addr  [NREQ*AW-1:0] - per-requester register index
//               lock  [NREQ-1:0]    - per-requester bus lock (ARB_LOCK_EN)
//               gnt   [NREQ-1:0]    - one-hot grant
//               reg_ie[NREG-1:0]    - one-hot register input enable
//               write_ctrl          - global write qualifier
//               reg_oe[NREG-1:0]    - one-hot register output enable
//               done, err           - completion / out-of-range pulses
// Config      : define ARB_LOCK_EN to add the lock port; a locked winner goes
//               ACCESS -> GRANT with freshly latched wr/addr and keeps ptr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NREQ = c_NREQ_DEF,
    parameter  int NREG = c_NREG_DEF,
    localparam int AW   = aw_of(NREG),
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*AW-1:0]   addr,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      reg_ie,
    output logic                 write_ctrl,
    output logic [NREG-1:0]      reg_oe,
    output logic                 done,
    output logic                 err
);

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic            r_wr;
    logic [AW-1:0]   r_addr;

    arb_state_t      w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_win_nxt;
    logic            w_wr_nxt;
    logic [AW-1:0]   w_addr_nxt;

    logic [NREQ-1:0] w_pick_oh;
    logic [PW-1:0]   w_pick_idx;
    logic [PW-1:0]   w_sel_idx;
    logic            w_sel_wr;
    logic [AW-1:0]   w_sel_addr;
    logic [PW-1:0]   w_ptr_inc;
    logic            w_in_range;
    logic            w_lock_hold;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_pick_oh)
    );

    always_comb begin : p_pick_encode
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_idx = PW'(i);
            end
        end
    end

    // In IDLE the fresh winner's operands are latched; in ACCESS (lock
    // re-grant) the current winner's operands are re-latched.
    assign w_sel_idx = (r_state == ST_IDLE) ? w_pick_idx : r_win;

    always_comb begin : p_sel_mux
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_idx == PW'(i)) begin
                w_sel_wr   = wr[i];
                w_sel_addr = addr[i*AW +: AW];
            end
        end
    end

    assign w_ptr_inc  = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);
    assign w_in_range = (r_addr < AW'(NREG));

`ifdef ARB_LOCK_EN
    assign w_lock_hold = lock[r_win];
`else
    assign w_lock_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin : p_fsm_seq
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin : p_fsm_comb
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        gnt         = '0;
        reg_ie      = '0;
        reg_oe      = '0;
        write_ctrl  = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_win_nxt   = w_pick_idx;
                    w_wr_nxt    = w_sel_wr;
                    w_addr_nxt  = w_sel_addr;
                end
            end

            ST_GRANT: begin
                gnt[r_win] = 1'b1;
                // A requester that withdraws here aborts without consuming
                // its round-robin turn.
                w_state_nxt = req[r_win] ? ST_ACCESS : ST_IDLE;
            end

            ST_ACCESS: begin
                gnt[r_win] = 1'b1;
                done       = 1'b1;
                err        = !w_in_range;
                write_ctrl = r_wr && w_in_range;
                // Out-of-range indices match no bit, so no enable asserts.
                for (int i = 0; i < NREG; i++) begin
                    reg_ie[i] = r_wr  && (r_addr == AW'(i));
                    reg_oe[i] = !r_wr && (r_addr == AW'(i));
                end
                if (w_lock_hold) begin
                    w_state_nxt = ST_GRANT;
                    w_wr_nxt    = w_sel_wr;
                    w_addr_nxt  = w_sel_addr;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_ptr_inc;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
//==============================================================================
// Module      : tb_reg_bus_arbiter
// Description : Self-checking bench for reg_bus_arbiter: vector table,
//               directed multi-cycle sequences and a randomized run against a
//               transaction-level reference model. Lock coverage is included
//               when ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_bus_arbiter;
    import reg_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int AW   = aw_of(NREG);

    logic                clk = 1'b0;
    logic                clr_n;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     wr;
    logic [NREQ*AW-1:0]  addr;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]     lock;
`endif
    logic [NREQ-1:0]     gnt;
    logic [NREG-1:0]     reg_ie;
    logic                write_ctrl;
    logic [NREG-1:0]     reg_oe;
    logic                done;
    logic                err;

    reg_bus_arbiter #(
        .NREQ       (NREQ),
        .NREG       (NREG)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
`ifdef ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt        (gnt),
        .reg_ie     (reg_ie),
        .write_ctrl (write_ctrl),
        .reg_oe     (reg_oe),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Register bank driven by the arbiter's enables.
    logic [63:0] regs [NREG];
    logic [63:0] wdata;
    logic        bank_clr;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_clr)                    regs[i] <= '0;
            else if (write_ctrl && reg_ie[i]) regs[i] <= wdata;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [3:0]  gnt;
        logic [7:0]  ie;
        logic [7:0]  oe;
        logic        wc;
        logic        dn;
        logic        er;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                                input logic [15:0] a, input logic [3:0] g,
                                input logic [7:0] ie, input logic [7:0] oe,
                                input logic wc, input logic dn, input logic er);
        vec_t v;
        v.req = r; v.wr = w; v.addr = a; v.gnt = g;
        v.ie = ie; v.oe = oe; v.wc = wc; v.dn = dn; v.er = er;
        return v;
    endfunction

    function automatic logic [15:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [15:0] a);
        req  = r;
        wr   = w;
        addr = a;
    endtask

    task automatic check_out(input string name, input logic [3:0] e_gnt,
                             input logic [7:0] e_ie, input logic [7:0] e_oe,
                             input logic e_wc, input logic e_dn, input logic e_er);
        logic [22:0] act;
        logic [22:0] exp;
        act = {gnt, reg_ie, reg_oe, write_ctrl, done, err};
        exp = {e_gnt, e_ie, e_oe, e_wc, e_dn, e_er};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b ie=%h oe=%h wc=%b done=%b err=%b, want gnt=%b ie=%h oe=%h wc=%b done=%b err=%b",
                     name, gnt, reg_ie, reg_oe, write_ctrl, done, err,
                     e_gnt, e_ie, e_oe, e_wc, e_dn, e_er);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: phase 0 = arbitrating, 1 = granted,
    // 2 = accessing.
    int m_phase, m_ptr, m_win, m_wr, m_addr;

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_wr = 0; m_addr = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] w,
                              input logic [15:0] a, input logic [3:0] lk);
        bit found;
        found = 0;
        case (m_phase)
            0: begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (!found && r[i]) begin
                        found   = 1;
                        m_win   = i;
                        m_wr    = int'(w[i]);
                        m_addr  = int'(a[i*4 +: 4]);
                        m_phase = 1;
                    end
                end
            end
            1: m_phase = r[m_win] ? 2 : 0;
            default: begin
                if (lk[m_win]) begin
                    m_wr    = int'(w[m_win]);
                    m_addr  = int'(a[m_win*4 +: 4]);
                    m_phase = 1;
                end else begin
                    m_ptr   = (m_win + 1) % NREQ;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic model_check(input string name);
        logic [3:0] e_gnt;
        logic [7:0] e_ie, e_oe;
        logic       e_wc, e_dn, e_er;
        e_gnt = '0; e_ie = '0; e_oe = '0; e_wc = 0; e_dn = 0; e_er = 0;
        if (m_phase != 0) e_gnt = 4'(1 << m_win);
        if (m_phase == 2) begin
            e_dn = 1;
            if (m_addr < NREG) begin
                if (m_wr != 0) begin e_ie = 8'(1 << m_addr); e_wc = 1; end
                else           e_oe = 8'(1 << m_addr);
            end else begin
                e_er = 1;
            end
        end
        check_out(name, e_gnt, e_ie, e_oe, e_wc, e_dn, e_er);
    endtask

    vec_t vecs [18];

    initial begin
        int n;
        logic [3:0]  r_req, r_wr, lk;
        logic [15:0] r_addr;

        // Vector table: five round-robin reads, then a single write.
        n = 0;
        for (int t = 0; t < 5; t++) begin
            int w;
            w = t % 4;
            vecs[n] = mk(4'hF, 4'h0, pk(4, 3, 2, 1), 4'(1 << w), 8'h00, 8'h00, 0, 0, 0); n++;
            vecs[n] = mk(4'hF, 4'h0, pk(4, 3, 2, 1), 4'(1 << w), 8'h00, 8'(1 << (w + 1)), 0, 1, 0); n++;
            vecs[n] = mk(4'hF, 4'h0, pk(4, 3, 2, 1), 4'h0, 8'h00, 8'h00, 0, 0, 0); n++;
        end
        vecs[n] = mk(4'h1, 4'h1, pk(0, 0, 0, 3), 4'h1, 8'h00, 8'h00, 0, 0, 0); n++;
        vecs[n] = mk(4'h1, 4'h1, pk(0, 0, 0, 3), 4'h1, 8'h08, 8'h00, 1, 1, 0); n++;
        vecs[n] = mk(4'h0, 4'h0, pk(0, 0, 0, 0), 4'h0, 8'h00, 8'h00, 0, 0, 0); n++;

        clr_n    = 1'b0;
        bank_clr = 1'b1;
        wdata    = 64'hA5A5_0000_0000_0003;
        drive(4'h0, 4'h0, 16'h0);
`ifdef ARB_LOCK_EN
        lock = 4'h0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 4'h0, 8'h00, 8'h00, 0, 0, 0);
        @(negedge clk);
        clr_n    = 1'b1;
        bank_clr = 1'b0;

        for (int k = 0; k < n; k++) begin
            drive(vecs[k].req, vecs[k].wr, vecs[k].addr);
            tick();
            check_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].ie, vecs[k].oe,
                      vecs[k].wc, vecs[k].dn, vecs[k].er);
        end
        check_val("reg3_written", regs[3], 64'hA5A5_0000_0000_0003);

        // Requester 1 read moves the pointer to 2.
        drive(4'b0010, 4'h0, pk(0, 0, 5, 0));
        tick(); check_out("r1_grant", 4'b0010, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("r1_access", 4'b0010, 8'h00, 8'h20, 0, 1, 0);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("r1_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);

        // Requester 2 withdraws in GRANT; pointer must stay at 2.
        drive(4'b0101, 4'h0, pk(0, 6, 0, 7));
        tick(); check_out("r2_grant", 4'b0100, 8'h00, 8'h00, 0, 0, 0);
        drive(4'b0001, 4'h0, pk(0, 6, 0, 7));
        tick(); check_out("r2_abort", 4'h0, 8'h00, 8'h00, 0, 0, 0);
        drive(4'b0101, 4'h0, pk(0, 6, 0, 7));
        tick(); check_out("r2_regrant", 4'b0100, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("r2_access", 4'b0100, 8'h00, 8'h40, 0, 1, 0);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("r2_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);

        // Out-of-range index from requester 3.
        drive(4'b1000, 4'h0, pk(9, 0, 0, 0));
        tick(); check_out("oor_grant", 4'b1000, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("oor_access", 4'b1000, 8'h00, 8'h00, 0, 1, 1);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("oor_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);

        // Requester 0 read: pointer becomes 1 before the reset test.
        drive(4'b0001, 4'h0, pk(0, 0, 0, 2));
        tick(); check_out("r0_grant", 4'b0001, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("r0_access", 4'b0001, 8'h00, 8'h04, 0, 1, 0);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("r0_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);

        // Reset during a write ACCESS.
        wdata = 64'h1234_5678_9ABC_DEF0;
        drive(4'b0100, 4'b0100, pk(0, 5, 0, 0));
        tick(); check_out("rst_grant", 4'b0100, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("rst_access", 4'b0100, 8'h20, 8'h00, 1, 1, 0);
        #2;
        clr_n = 1'b0;
        drive(4'b1001, 4'h0, pk(2, 0, 0, 1));
        #1;
        check_out("rst_immediate", 4'h0, 8'h00, 8'h00, 0, 0, 0);
        tick();
        check_val("reg5_not_written", regs[5], 64'h0);
        @(negedge clk);
        clr_n = 1'b1;
        tick(); check_out("rst_resume_ptr0", 4'b0001, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("rst_resume_access", 4'b0001, 8'h00, 8'h02, 0, 1, 0);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("rst_resume_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);

`ifdef ARB_LOCK_EN
        // Pointer is 1: requester 1 locks for two accesses, then 0 is served.
        drive(4'b0011, 4'h0, pk(0, 0, 2, 3));
        lock = 4'b0010;
        tick(); check_out("lock_grant1", 4'b0010, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("lock_access1", 4'b0010, 8'h00, 8'h04, 0, 1, 0);
        drive(4'b0011, 4'h0, pk(0, 0, 6, 3));
        tick(); check_out("lock_regrant", 4'b0010, 8'h00, 8'h00, 0, 0, 0);
        lock = 4'b0000;
        tick(); check_out("lock_access2", 4'b0010, 8'h00, 8'h40, 0, 1, 0);
        tick(); check_out("lock_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("lock_next_r0", 4'b0001, 8'h00, 8'h00, 0, 0, 0);
        tick(); check_out("lock_r0_access", 4'b0001, 8'h00, 8'h08, 0, 1, 0);
        drive(4'h0, 4'h0, 16'h0);
        tick(); check_out("lock_r0_turn", 4'h0, 8'h00, 8'h00, 0, 0, 0);
`endif

        // Randomized run against the reference model from a fresh reset.
        @(negedge clk);
        clr_n = 1'b0;
        drive(4'h0, 4'h0, 16'h0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        r_req = 4'h0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 0) r_req = 4'($urandom_range(0, 15));
            r_wr   = 4'($urandom_range(0, 15));
            r_addr = 16'($urandom);
            lk     = 4'h0;
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 3) == 0) lk = 4'($urandom_range(0, 15));
            lock = lk;
`endif
            wdata = {$urandom, $urandom};
            drive(r_req, r_wr, r_addr);
            model_step(r_req, r_wr, r_addr, lk);
            tick();
            model_check($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
